// File: rtl/fft_pkg.sv
// Shared FFT definitions: result-reader FSM states and bit-reverse helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FINISH = 2'd2
   } fft_rd_state_e;

   // Reverse the low 'width' bits of idx; bits at and above 'width' come back zero.
   // Shift-based so the function stays free of variable bit indexing.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
      logic [31:0] src;
      logic [31:0] res;
      src = idx;
      res = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            res = {res[30:0], src[0]};
            src = src >> 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_rd_fifo.sv
// Two-entry synchronous FIFO holding returned FFT words plus their last tag.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push is ignored when full and pop when empty; the producer's credit logic keeps it from pushing into a full FIFO.
module fft_rd_fifo #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] slot_q [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign full      = (count == 2'd2);
   assign empty     = (count == 2'd0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = slot_q[rd_ptr];

   // Storage, pointers and occupancy; reset empties the FIFO and clears the slots.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
      end else begin
         if (do_push) begin
            slot_q[wr_ptr] <= push_data;
            wr_ptr         <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/fft_rd_streamer.sv
// Reads all N FFT results after 'done' and streams them out in natural frequency order.
// Latency: first read the cycle after done_i, first beat 3 cycles after done_i, then one beat per cycle.
// Backpressure: credit-limited to 2 reads in flight or buffered; reads resume the cycle a pop frees credit.
module fft_rd_streamer
   import fft_pkg::*;
#(
   parameter int N_POINTS    = 16,
   parameter int DATA_W      = 32,
   parameter int BIT_REVERSE = 1,
   localparam int ADDR_W     = $clog2(N_POINTS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              done_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_last_o,
   output logic              busy_o,
   output logic              rd_done_o,
   output logic              overrun_o
);

   localparam logic [ADDR_W:0] K_END  = (ADDR_W + 1)'(N_POINTS);
   localparam logic [ADDR_W:0] K_LAST = (ADDR_W + 1)'(N_POINTS - 1);

   fft_rd_state_e     state;
   logic [ADDR_W:0]   k;
   logic              inflight;
   logic              inflight_last;
   logic              pop;
   logic              credit_ok;
   logic              rd_en;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [1:0]        fifo_count;
   logic [DATA_W:0]   fifo_head;
   logic [ADDR_W-1:0] k_addr;
   logic [ADDR_W-1:0] rev_addr;

   // Credit counts words buffered plus the one possibly in flight, minus the word leaving now.
   assign pop       = !fifo_empty && m_ready_i;
   assign credit_ok = ({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
   assign rd_en     = (state == STREAM) && (k < K_END) && credit_ok;
   assign fifo_push = inflight && !fifo_full;

   assign k_addr      = k[ADDR_W-1:0];
   assign rev_addr    = ADDR_W'(bitrev(32'(k_addr), ADDR_W));
   assign mem_rd_en_o = rd_en;
   assign mem_addr_o  = (BIT_REVERSE != 0) ? rev_addr : k_addr;

   // Outputs are forced to zero while nothing is buffered so stale FIFO slots never leak out.
   assign m_valid_o = !fifo_empty;
   assign m_data_o  = m_valid_o ? fifo_head[DATA_W-1:0] : '0;
   assign m_last_o  = m_valid_o && fifo_head[DATA_W];

   fft_rd_fifo #(
      .W (DATA_W + 1)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (fifo_push),
      .push_data ({inflight_last, mem_rdata_i}),
      .pop       (pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Issue counter and one-deep in-flight tracker matching the 1-cycle memory read latency.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         k             <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= rd_en;
         inflight_last <= rd_en && (k == K_LAST);
         if ((state == IDLE) && done_i) begin
            k <= '0;
         end else if (rd_en) begin
            k <= k + (ADDR_W + 1)'(1);
         end
      end
   end

   // Frame FSM with registered busy/rd_done and the sticky overrun flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         busy_o    <= 1'b0;
         rd_done_o <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         rd_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (done_i) begin
                  state  <= STREAM;
                  busy_o <= 1'b1;
               end
            end
            STREAM: begin
               if (done_i) begin
                  overrun_o <= 1'b1;
               end
               if (pop && m_last_o) begin
                  state     <= FINISH;
                  rd_done_o <= 1'b1;
               end
            end
            FINISH: begin
               if (done_i) begin
                  overrun_o <= 1'b1;
               end
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_rd_streamer.sv
// Self-checking bench for fft_rd_streamer: instance 0 bit-reversed, instance 1 linear.
// Latency: checks exact cycle timing of a frame and frame completion under random stalls.
// Backpressure: random and long stalls on m_ready_i, with a scoreboard on outstanding reads.
module tb_fft_rd_streamer;

   localparam int N  = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;

   logic [1:0]         done_s;
   logic [1:0]         ready_s;
   logic [1:0]         rd_en_s;
   logic [1:0]         valid_s;
   logic [1:0]         last_s;
   logic [1:0]         busy_s;
   logic [1:0]         rd_done_s;
   logic [1:0]         overrun_s;
   logic [1:0][3:0]    addr_s;
   logic [1:0][DW-1:0] rdata_s;
   logic [1:0][DW-1:0] data_s;

   logic [DW-1:0] mem [2][N];

   int rev_tab [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   int          n_checks = 0;
   int          n_errors = 0;
   int          beat_cnt;
   int          rd_cnt;
   int          rd_done_cnt;
   bit          prev_stall;
   logic [DW-1:0] held_data;
   logic        held_last;

   typedef struct {
      logic        done;
      logic        ready;
      logic        rd_en;
      logic [3:0]  addr;
      logic        valid;
      logic [DW-1:0] data;
      logic        last;
      logic        busy;
      logic        rd_done;
   } vec_t;

   vec_t tab [21];

   always #5 clk = ~clk;

   fft_rd_streamer #(.N_POINTS(N), .DATA_W(DW), .BIT_REVERSE(1)) u_rev (
      .clk_i       (clk),
      .rst_i       (rst),
      .done_i      (done_s[0]),
      .mem_rd_en_o (rd_en_s[0]),
      .mem_addr_o  (addr_s[0]),
      .mem_rdata_i (rdata_s[0]),
      .m_valid_o   (valid_s[0]),
      .m_ready_i   (ready_s[0]),
      .m_data_o    (data_s[0]),
      .m_last_o    (last_s[0]),
      .busy_o      (busy_s[0]),
      .rd_done_o   (rd_done_s[0]),
      .overrun_o   (overrun_s[0])
   );

   fft_rd_streamer #(.N_POINTS(N), .DATA_W(DW), .BIT_REVERSE(0)) u_lin (
      .clk_i       (clk),
      .rst_i       (rst),
      .done_i      (done_s[1]),
      .mem_rd_en_o (rd_en_s[1]),
      .mem_addr_o  (addr_s[1]),
      .mem_rdata_i (rdata_s[1]),
      .m_valid_o   (valid_s[1]),
      .m_ready_i   (ready_s[1]),
      .m_data_o    (data_s[1]),
      .m_last_o    (last_s[1]),
      .busy_o      (busy_s[1]),
      .rd_done_o   (rd_done_s[1]),
      .overrun_o   (overrun_s[1])
   );

   // Synchronous-read memory model: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en_s[0]) rdata_s[0] <= mem[0][addr_s[0]];
      if (rd_en_s[1]) rdata_s[1] <= mem[1][addr_s[1]];
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory address holding output beat i.
   function automatic int exp_addr(input int inst, input int i);
      return (inst == 0) ? rev_tab[i] : i;
   endfunction

   task automatic check_zero(input int inst);
      check("zero_rd_en",   rd_en_s[inst],   0);
      check("zero_addr",    addr_s[inst],    0);
      check("zero_valid",   valid_s[inst],   0);
      check("zero_data",    data_s[inst],    0);
      check("zero_last",    last_s[inst],    0);
      check("zero_busy",    busy_s[inst],    0);
      check("zero_rd_done", rd_done_s[inst], 0);
      check("zero_overrun", overrun_s[inst], 0);
   endtask

   // Scoreboard for one cycle, called away from the clock edge.
   task automatic mon_cycle(input int inst);
      int idx;
      int outstanding;
      if (prev_stall) begin
         check("hold_valid", valid_s[inst], 1);
         check("hold_data",  data_s[inst],  held_data);
         check("hold_last",  last_s[inst],  held_last);
      end
      if (rd_en_s[inst]) begin
         idx = rd_cnt % N;
         check("rd_addr", addr_s[inst], exp_addr(inst, idx));
         check("rd_while_busy", busy_s[inst], 1);
         rd_cnt++;
      end
      outstanding = rd_cnt - beat_cnt - ((valid_s[inst] && ready_s[inst]) ? 1 : 0);
      check("outstanding_le2", outstanding <= 2, 1);
      if (valid_s[inst] && ready_s[inst]) begin
         idx = beat_cnt % N;
         check("beat_data", data_s[inst], mem[inst][exp_addr(inst, idx)]);
         check("beat_last", last_s[inst], idx == N - 1);
         beat_cnt++;
      end
      prev_stall = valid_s[inst] && !ready_s[inst];
      held_data  = data_s[inst];
      held_last  = last_s[inst];
      if (rd_done_s[inst]) rd_done_cnt++;
   endtask

   task automatic cycle(input int inst);
      @(negedge clk);
      mon_cycle(inst);
      @(posedge clk);
      #1;
      done_s[inst] = 1'b0;
   endtask

   task automatic clear_frame();
      beat_cnt    = 0;
      rd_cnt      = 0;
      rd_done_cnt = 0;
      prev_stall  = 1'b0;
   endtask

   // mode 1: ready held high; mode 0: ready random 50%.
   task automatic run_until(input int inst, input int mode, input int target, input int budget,
                            input int redone_at);
      int cyc;
      cyc = 0;
      while (rd_done_cnt < target && cyc < budget) begin
         if (cyc == redone_at) done_s[inst] = 1'b1;
         ready_s[inst] = (mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
         cycle(inst);
         cyc++;
      end
      check("frame_completed", rd_done_cnt >= target, 1);
   endtask

   initial begin
      int cyc;
      rst     = 1'b1;
      done_s  = '0;
      ready_s = '0;
      for (int a = 0; a < N; a++) begin
         mem[0][a] = DW'(a);
         mem[1][a] = $urandom;
      end

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_zero(0);
      check_zero(1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Cycle-exact frame on the bit-reversed instance, memory[a] = a, ready high.
      for (int d = 0; d < 21; d++) begin
         tab[d].done    = (d == 0);
         tab[d].ready   = 1'b1;
         tab[d].rd_en   = (d >= 1 && d <= N);
         tab[d].addr    = '0;
         if (tab[d].rd_en) tab[d].addr = 4'(rev_tab[d-1]);
         tab[d].valid   = (d >= 3 && d <= N + 2);
         tab[d].data    = '0;
         if (tab[d].valid) tab[d].data = DW'(rev_tab[d-3]);
         tab[d].last    = (d == N + 2);
         tab[d].busy    = (d >= 1 && d <= N + 3);
         tab[d].rd_done = (d == N + 3);
      end
      for (int d = 0; d < 21; d++) begin
         done_s[0]  = tab[d].done;
         ready_s[0] = tab[d].ready;
         @(negedge clk);
         check("tab_rd_en", rd_en_s[0], tab[d].rd_en);
         if (tab[d].rd_en) check("tab_addr", addr_s[0], tab[d].addr);
         check("tab_valid", valid_s[0], tab[d].valid);
         if (tab[d].valid) check("tab_data", data_s[0], tab[d].data);
         check("tab_last", last_s[0], tab[d].last);
         check("tab_busy", busy_s[0], tab[d].busy);
         check("tab_rd_done", rd_done_s[0], tab[d].rd_done);
         @(posedge clk);
         #1;
      end
      done_s[0] = 1'b0;

      // Linear instance, random ready, two frames.
      for (int f = 0; f < 2; f++) begin
         clear_frame();
         done_s[1] = 1'b1;
         run_until(1, 0, 1, 300, -1);
         check("rand_beats", beat_cnt, N);
         check("rand_reads", rd_cnt, N);
         check("rand_rd_done", rd_done_cnt, 1);
      end

      // Long stall right after start: only two reads may go out.
      clear_frame();
      done_s[1]  = 1'b1;
      ready_s[1] = 1'b0;
      repeat (20) cycle(1);
      check("stall_reads", rd_cnt, 2);
      check("stall_valid", valid_s[1], 1);
      check("stall_data", data_s[1], mem[1][0]);
      run_until(1, 1, 1, 100, -1);
      check("stall_total_reads", rd_cnt, N);
      check("stall_total_beats", beat_cnt, N);

      // done_i re-pulsed mid-frame.
      check("overrun_before", overrun_s[0], 0);
      clear_frame();
      done_s[0] = 1'b1;
      run_until(0, 1, 1, 100, 6);
      check("ovr_beats", beat_cnt, N);
      check("ovr_rd_done", rd_done_cnt, 1);
      check("ovr_flag", overrun_s[0], 1);
      ready_s[0] = 1'b1;
      repeat (3) cycle(0);
      check("ovr_sticky", overrun_s[0], 1);
      check("ovr_no_new_frame", busy_s[0], 0);
      check("ovr_no_new_reads", rd_cnt, N);

      // Reset during beat 5, then a fresh frame.
      clear_frame();
      done_s[1] = 1'b1;
      cyc = 0;
      while (beat_cnt < 5 && cyc < 50) begin
         ready_s[1] = 1'b1;
         cycle(1);
         cyc++;
      end
      check("mid_reached_beat5", beat_cnt, 5);
      rst = 1'b1;
      @(negedge clk);
      check_zero(1);
      check_zero(0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_frame();
      done_s[1] = 1'b1;
      run_until(1, 1, 1, 100, -1);
      check("post_rst_beats", beat_cnt, N);
      check("post_rst_reads", rd_cnt, N);

      // Back-to-back frames, second done_i in the first IDLE cycle.
      for (int a = 0; a < N; a++) mem[0][a] = $urandom;
      clear_frame();
      done_s[0] = 1'b1;
      run_until(0, 1, 1, 100, -1);
      check("b2b_idle_gap", busy_s[0], 0);
      done_s[0] = 1'b1;
      run_until(0, 1, 2, 100, -1);
      check("b2b_beats", beat_cnt, 2 * N);
      check("b2b_reads", rd_cnt, 2 * N);
      check("b2b_rd_done", rd_done_cnt, 2);
      check("b2b_overrun", overrun_s[0], 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
